lcd_timing_rx: RTL

Parallel RGB video receiver: samples an LCD-style RGB/HS/VS/DE stream on its pixel clock and recovers pixel coordinates and frame/line markers. It measures the incoming timing (total and active sizes) and declares lock after two consecutive identical frames. It sits at the capture end of an RGB link, feeding downstream buffering and processing with an `(x, y, data, valid)` pixel stream.

---
 rtl/lcd_timing_rx.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_timing_rx.sv
`timescale 1ns/1ps
// lcd_timing_rx: parallel RGB/HS/VS/DE receiver.
// Measures frame timing, detects lock, emits an (x, y, data, valid) stream.
module lcd_timing_rx #(
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic        vid_de,
    input  logic [23:0] vid_rgb,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic [10:0] meas_h_total,
    output logic [10:0] meas_h_disp,
    output logic [10:0] meas_v_total,
    output logic [10:0] meas_v_disp,
    output logic        locked,
    output logic        fmt_err
);

    localparam logic [10:0] CMAX = 11'd2047;

    typedef enum logic [1:0] {IDLE, MEAS1, MEAS2, LOCK} state_t;

    logic        hs1_q, vs1_q, de1_q;
    logic [23:0] rgb1_q;
    logic        hs_edge, vs_edge, de_fall;

    logic [10:0] hcnt_q, hcnt_d, hde_q, hde_d;
    logic [10:0] lcnt_q, lcnt_d, dl_q, dl_d;
    logic [10:0] hlast_q, hlast_d, hmax_q, hmax_d;
    logic [10:0] lcnt_x, dl_x, hlast_x, hmax_x;
    logic        ovf_q, ovf_d, ovf_set, ovf_now;
    logic [43:0] cand;

    state_t      state_q, state_d;
    logic [43:0] r_q, r_d, meas_q, meas_d;
    logic        locked_q, locked_d, fmt_err_q, fmt_err_d;

    logic        pv_q, pv_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic [23:0] pdata_q, pdata_d;
    logic [10:0] px_q, px_d, py_q, py_d, ycnt_q, ycnt_d, x_cur;

    // Sync edges: s1 inactive while the raw pin (s0) is active.
    assign hs_edge = (vid_hs == HS_POL) && (hs1_q != HS_POL);
    assign vs_edge = (vid_vs == VS_POL) && (vs1_q != VS_POL);
    assign de_fall = de1_q && !vid_de;

    // Input stage s1.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hs1_q  <= ~HS_POL;
            vs1_q  <= ~VS_POL;
            de1_q  <= 1'b0;
            rgb1_q <= '0;
        end else begin
            hs1_q  <= vid_hs;
            vs1_q  <= vid_vs;
            de1_q  <= vid_de;
            rgb1_q <= vid_rgb;
        end
    end

    // Line accounting: saturating counters, HS edge handled before VS edge.
    always_comb begin
        ovf_set = 1'b0;
        hcnt_d  = hcnt_q;
        hde_d   = hde_q;
        lcnt_x  = lcnt_q;
        dl_x    = dl_q;
        hlast_x = hlast_q;
        hmax_x  = hmax_q;
        if (hs_edge) begin
            hcnt_d  = '0;
            hde_d   = '0;
            hlast_x = hcnt_q + 11'd1;
            if (hde_q > hmax_q) hmax_x = hde_q;
            if (lcnt_q == CMAX) ovf_set = 1'b1;
            else lcnt_x = lcnt_q + 11'd1;
            if (hde_q != '0) begin
                if (dl_q == CMAX) ovf_set = 1'b1;
                else dl_x = dl_q + 11'd1;
            end
        end else begin
            if (hcnt_q == CMAX) ovf_set = 1'b1;
            else hcnt_d = hcnt_q + 11'd1;
            if (de1_q) begin
                if (hde_q == CMAX) ovf_set = 1'b1;
                else hde_d = hde_q + 11'd1;
            end
        end
    end

    assign ovf_now = ovf_q | ovf_set;
    assign cand    = {hlast_x, hmax_x, lcnt_x, dl_x};
    assign hlast_d = hlast_x;
    assign lcnt_d  = vs_edge ? 11'd0 : lcnt_x;
    assign dl_d    = vs_edge ? 11'd0 : dl_x;
    assign hmax_d  = vs_edge ? 11'd0 : hmax_x;
    assign ovf_d   = vs_edge ? 1'b0 : ovf_now;

    // Timing counter registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcnt_q  <= '0;
            hde_q   <= '0;
            lcnt_q  <= '0;
            dl_q    <= '0;
            hlast_q <= '0;
            hmax_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            hde_q   <= hde_d;
            lcnt_q  <= lcnt_d;
            dl_q    <= dl_d;
            hlast_q <= hlast_d;
            hmax_q  <= hmax_d;
            ovf_q   <= ovf_d;
        end
    end

    // Lock FSM: compares each frame's candidate timing against the reference.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        meas_d    = meas_q;
        locked_d  = locked_q;
        fmt_err_d = 1'b0;
        if (vs_edge) begin
            fmt_err_d = ovf_now;
            unique case (state_q)
                IDLE: state_d = MEAS1;
                MEAS1: begin
                    r_d     = cand;
                    state_d = MEAS2;
                end
                MEAS2: begin
                    if (cand == r_q && !ovf_now) begin
                        state_d  = LOCK;
                        locked_d = 1'b1;
                        meas_d   = r_q;
                    end else begin
                        r_d = cand;
                    end
                end
                LOCK: begin
                    if (cand != r_q || ovf_now) begin
                        fmt_err_d = 1'b1;
                        locked_d  = 1'b0;
                        r_d       = cand;
                        state_d   = MEAS2;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Lock FSM registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            meas_q    <= '0;
            locked_q  <= 1'b0;
            fmt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            meas_q    <= meas_d;
            locked_q  <= locked_d;
            fmt_err_q <= fmt_err_d;
        end
    end

    // Pixel path: s1 -> s2 with coordinates and frame/line markers.
    always_comb begin
        x_cur   = pv_q ? px_q + 11'd1 : 11'd0;
        pv_d    = de1_q;
        pdata_d = de1_q ? rgb1_q : 24'd0;
        px_d    = de1_q ? x_cur : px_q;
        py_d    = de1_q ? ycnt_q : py_q;
        eol_d   = de_fall;
        sof_d   = de1_q && x_cur == 11'd0 && ycnt_q == 11'd0;
        eof_d   = de_fall && locked_q
                  && ycnt_q == meas_q[10:0] - 11'd1;
        ycnt_d  = ycnt_q;
        if (vs_edge) ycnt_d = '0;
        else if (de_fall && ycnt_q != CMAX) ycnt_d = ycnt_q + 11'd1;
    end

    // Pixel output registers (stage s2).
    always_ff @(posedge pclk) begin
        if (rst) begin
            pv_q    <= 1'b0;
            pdata_q <= '0;
            px_q    <= '0;
            py_q    <= '0;
            ycnt_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            pv_q    <= pv_d;
            pdata_q <= pdata_d;
            px_q    <= px_d;
            py_q    <= py_d;
            ycnt_q  <= ycnt_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    assign pix_valid    = pv_q;
    assign pix_data     = pdata_q;
    assign pix_x        = px_q;
    assign pix_y        = py_q;
    assign sof          = sof_q;
    assign eol          = eol_q;
    assign eof          = eof_q;
    assign meas_h_total = meas_q[43:33];
    assign meas_h_disp  = meas_q[32:22];
    assign meas_v_total = meas_q[21:11];
    assign meas_v_disp  = meas_q[10:0];
    assign locked       = locked_q;
    assign fmt_err      = fmt_err_q;

endmodule
